// File: rtl/dispatcher_reuse_mc.sv
`default_nettype none
// ============================================================================
// Module      : dispatcher_reuse_mc
// Description : Activation/weight dispatcher with a group reuse buffer. It
//               emits representative elements paired with the weights of the
//               current iteration. Optional macro ZERO_SKIP_EN drops
//               zero-flagged elements.
// Revision    : 1.0 - initial release
// ============================================================================
module dispatcher_reuse_mc #(
    parameter int DATA_WIDTH             = 8,
    parameter int GROUP_SIZE             = 4,
    parameter int NUM_CH                 = 2,
    parameter int BUF_DEPTH              = 16,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16,
    localparam int c_IN_W  = GROUP_SIZE*DATA_WIDTH + GROUP_SIZE*GROUP_SIZE + GROUP_SIZE,
    localparam int c_OUT_W = DATA_WIDTH + NUM_CH*DATA_WIDTH + GROUP_SIZE + $clog2(GROUP_SIZE) + 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              configure,
    input  logic [LOG_MAX_ITERS-1:0]          num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
    input  logic [c_IN_W-1:0]                 act_data_in,
    input  logic                              act_valid_in,
    output logic                              act_avail_out,
    input  logic [NUM_CH*DATA_WIDTH-1:0]      weight_data_in,
    input  logic                              weight_valid_in,
    output logic                              weight_avail_out,
    output logic [c_OUT_W-1:0]                data_out,
    output logic                              valid_out,
    input  logic                              avail_in,
    output logic                              cfg_err
);

    localparam int c_IW    = $clog2(GROUP_SIZE);
    localparam int c_VAL_W = GROUP_SIZE*DATA_WIDTH;
    localparam int c_REP_W = GROUP_SIZE*GROUP_SIZE;
    localparam int c_WGT_W = NUM_CH*DATA_WIDTH;
    localparam int c_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
`ifdef ZERO_SKIP_EN
    localparam logic [GROUP_SIZE-1:0] c_ZERO_MASK = '1;
`else
    localparam logic [GROUP_SIZE-1:0] c_ZERO_MASK = '0;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_W = 2'd1,
        S_LOAD   = 2'd2,
        S_EMIT   = 2'd3
    } state_t;

    state_t                              r_state, w_state_nxt;
    logic [LOG_MAX_ITERS-1:0]            r_num_iters, r_iter;
    logic [LOG_MAX_READS_PER_ITER-1:0]   r_num_reads, r_grp_cnt;
    logic [c_WGT_W-1:0]                  r_weights;
    logic [c_IN_W-1:0]                   r_grp;
    logic [GROUP_SIZE-1:0]               r_pend;
    logic                                r_fresh;
    logic                                r_valid;
    logic [c_OUT_W-1:0]                  r_data;
    logic                                r_cfg_err;
    logic [c_IN_W-1:0]                   r_buf [BUF_DEPTH];

    logic                  w_cfg_ok, w_iter0, w_last_grp_cnt, w_last_iter_cnt;
    logic                  w_out_free, w_act_acc, w_is_new, w_emit_load, w_emit_done, w_load_out;
    logic [c_IN_W-1:0]     w_src_grp;
    logic [c_VAL_W-1:0]    w_src_vals;
    logic [c_REP_W-1:0]    w_src_rep;
    logic [GROUP_SIZE-1:0] w_src_zero, w_diag, w_src_pend, w_rest, w_rep_row;
    logic [c_IW-1:0]       w_idx;
    logic                  w_elem_last;
    logic [c_OUT_W-1:0]    w_out_word;

    assign w_cfg_ok        = (num_reads_per_iter != '0)
                          && (num_reads_per_iter <= LOG_MAX_READS_PER_ITER'(BUF_DEPTH))
                          && (num_iters != '0);
    assign w_iter0         = (r_iter == '0);
    assign w_last_grp_cnt  = (r_grp_cnt == r_num_reads - LOG_MAX_READS_PER_ITER'(1));
    assign w_last_iter_cnt = (r_iter == r_num_iters - LOG_MAX_ITERS'(1));
    assign w_out_free      = !r_valid || avail_in;
    assign w_act_acc       = (r_state == S_LOAD) && w_iter0 && act_valid_in;

    // In LOAD the incoming group is dispatched straight away; otherwise the held group.
    assign w_src_grp  = (r_state == S_LOAD) ? act_data_in : r_grp;
    assign w_src_vals = w_src_grp[c_VAL_W-1:0];
    assign w_src_rep  = w_src_grp[c_VAL_W +: c_REP_W];
    assign w_src_zero = w_src_grp[c_VAL_W+c_REP_W +: GROUP_SIZE];

    always_comb begin
        w_diag = '0;
        for (int i = 0; i < GROUP_SIZE; i++) begin
            w_diag[i] = w_src_rep[i*GROUP_SIZE + i];
        end
    end

    assign w_is_new   = (r_state == S_LOAD) || r_fresh;
    assign w_src_pend = w_is_new ? (w_diag & ~(w_src_zero & c_ZERO_MASK)) : r_pend;

    always_comb begin
        w_idx = '0;
        for (int i = GROUP_SIZE-1; i >= 0; i--) begin
            if (w_src_pend[i]) w_idx = c_IW'(i);
        end
    end

    // An empty pend set yields the bubble: idx 0, zero row, marked last of group.
    assign w_rest      = w_src_pend & ~(GROUP_SIZE'(1) << w_idx);
    assign w_elem_last = (w_rest == '0);
    assign w_rep_row   = (w_src_pend == '0) ? '0 : w_src_rep[w_idx*GROUP_SIZE +: GROUP_SIZE];
    assign w_out_word  = {w_elem_last && w_last_grp_cnt, w_elem_last, w_idx, w_rep_row,
                          r_weights, w_src_vals[w_idx*DATA_WIDTH +: DATA_WIDTH]};

    assign w_emit_load = (r_state == S_EMIT) && w_out_free && (r_fresh || (r_pend != '0));
    assign w_emit_done = (r_state == S_EMIT) && w_out_free && !r_fresh && (r_pend == '0);
    assign w_load_out  = w_act_acc || w_emit_load;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (configure && w_cfg_ok) w_state_nxt = S_WAIT_W;
            S_WAIT_W: if (weight_valid_in) w_state_nxt = S_LOAD;
            S_LOAD:   if (!w_iter0 || act_valid_in) w_state_nxt = S_EMIT;
            S_EMIT: begin
                if (w_emit_done) begin
                    if (!w_last_grp_cnt)       w_state_nxt = S_LOAD;
                    else if (!w_last_iter_cnt) w_state_nxt = S_WAIT_W;
                    else                       w_state_nxt = S_IDLE;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_act_acc) r_buf[r_grp_cnt[c_AW-1:0]] <= act_data_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_num_iters <= '0;
            r_num_reads <= '0;
            r_iter      <= '0;
            r_grp_cnt   <= '0;
            r_weights   <= '0;
            r_grp       <= '0;
            r_pend      <= '0;
            r_fresh     <= 1'b0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_cfg_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (configure) begin
                        if (w_cfg_ok) begin
                            r_num_iters <= num_iters;
                            r_num_reads <= num_reads_per_iter;
                            r_iter      <= '0;
                            r_cfg_err   <= 1'b0;
                        end else begin
                            r_cfg_err   <= 1'b1;
                        end
                    end
                end
                S_WAIT_W: begin
                    if (weight_valid_in) begin
                        r_weights <= weight_data_in;
                        r_grp_cnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (!w_iter0) begin
                        r_grp   <= r_buf[r_grp_cnt[c_AW-1:0]];
                        r_fresh <= 1'b1;
                    end else if (act_valid_in) begin
                        r_grp   <= act_data_in;
                    end
                end
                S_EMIT: begin
                    if (w_emit_done) begin
                        r_valid <= 1'b0;
                        if (!w_last_grp_cnt) begin
                            r_grp_cnt <= r_grp_cnt + LOG_MAX_READS_PER_ITER'(1);
                        end else begin
                            r_grp_cnt <= '0;
                            r_iter    <= w_last_iter_cnt ? '0 : r_iter + LOG_MAX_ITERS'(1);
                        end
                    end
                end
                default: ;
            endcase
            if (w_load_out) begin
                r_data  <= w_out_word;
                r_valid <= 1'b1;
                r_pend  <= w_rest;
                r_fresh <= 1'b0;
            end
        end
    end

    assign act_avail_out    = (r_state == S_LOAD) && w_iter0;
    assign weight_avail_out = (r_state == S_WAIT_W);
    assign data_out         = r_data;
    assign valid_out        = r_valid;
    assign cfg_err          = r_cfg_err;

endmodule
`default_nettype wire
